// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/control bundle between the EX/Decode hazard sources and the
// pipeline sequencing controller.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             MemReadE;
    logic [4:0]       RD_E;
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic             PCSrcE;
    logic             DivE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             DivStart;
    logic             DivDone;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output MemReadE, RD_E, Rs1_D, Rs2_D, PCSrcE, DivE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
               DivStart, DivDone, StallCount
    );

    modport slave (
        input  MemReadE, RD_E, Rs1_D, Rs2_D, PCSrcE, DivE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
               DivStart, DivDone, StallCount
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencing for load-use hazards, taken branches and the
// iterative divider, plus a saturating front-end stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int unsigned DIV_LATENCY = 8,
    parameter int unsigned CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int unsigned DCNT_W = $clog2(DIV_LATENCY);
    localparam logic [DCNT_W-1:0] DIV_LOAD = DCNT_W'(DIV_LATENCY - 2);

    typedef enum logic {IDLE, DIV_BUSY} state_t;

    state_t             state_q, state_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic stall_f, stall_d, stall_e;
    logic flush_d, flush_e, flush_m;
    logic div_start, div_done;
    logic load_use;

    assign load_use = bus.MemReadE && (bus.RD_E != '0) &&
                      ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D));

    // Outputs are forced low while reset is asserted, even though inputs may toggle.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_m   = 1'b0;
        div_start = 1'b0;
        div_done  = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.PCSrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (bus.DivE) begin
                        div_start = 1'b1;
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        flush_m   = 1'b1;
                        dcnt_d    = DIV_LOAD;
                        state_d   = DIV_BUSY;
                    end else if (load_use) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                DIV_BUSY: begin
                    if (dcnt_q == '0) begin
                        div_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                        dcnt_d  = dcnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_f && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            dcnt_q        <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            dcnt_q        <= dcnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.StallF     = stall_f;
    assign bus.StallD     = stall_d;
    assign bus.StallE     = stall_e;
    assign bus.FlushD     = flush_d;
    assign bus.FlushE     = flush_e;
    assign bus.FlushM     = flush_m;
    assign bus.DivStart   = div_start;
    assign bus.DivDone    = div_done;
    assign bus.StallCount = stall_count_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench: hazard, branch, divide, reset and counter-saturation cases.
module tb_pipeline_stall_ctrl;
    logic clk;
    logic rst;
    int unsigned errors;
    int unsigned checks;

    pipeline_stall_ctrl_if #(.CNT_W(16)) bif ();
    pipeline_stall_ctrl_if #(.CNT_W(4))  sif ();

    pipeline_stall_ctrl #(.DIV_LATENCY(8), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    pipeline_stall_ctrl #(.DIV_LATENCY(8), .CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    assign sif.MemReadE = bif.MemReadE;
    assign sif.RD_E     = bif.RD_E;
    assign sif.Rs1_D    = bif.Rs1_D;
    assign sif.Rs2_D    = bif.Rs2_D;
    assign sif.PCSrcE   = bif.PCSrcE;
    assign sif.DivE     = bif.DivE;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, DivStart, DivDone}
    logic [7:0] ctrl;
    assign ctrl = {bif.StallF, bif.StallD, bif.StallE, bif.FlushD,
                   bif.FlushE, bif.FlushM, bif.DivStart, bif.DivDone};

    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_LDUSE  = 8'b1100_1000;
    localparam logic [7:0] C_BRANCH = 8'b0001_1000;
    localparam logic [7:0] C_DSTART = 8'b1110_0110;
    localparam logic [7:0] C_DBUSY  = 8'b1110_0100;
    localparam logic [7:0] C_DDONE  = 8'b0000_0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic br, input logic dv);
        bif.MemReadE = mr;
        bif.RD_E     = rd;
        bif.Rs1_D    = r1;
        bif.Rs2_D    = r2;
        bif.PCSrcE   = br;
        bif.DivE     = dv;
        #1;
    endtask

    // One full 8-cycle divide; noise=1 drives branch/load-use/DivE during busy cycles.
    task automatic do_div(input string tag, input logic noise);
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            else        set_in(noise, 5'd5, 5'd5, 5'd5, noise, noise);
            if (k == 1)      check({tag, "_start"}, 32'(ctrl), 32'(C_DSTART));
            else if (k == 8) check({tag, "_done"},  32'(ctrl), 32'(C_DDONE));
            else             check({tag, "_busy"},  32'(ctrl), 32'(C_DBUSY));
            next_cycle();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("reset_ctrl", 32'(ctrl), 32'(C_NONE));
        check("reset_cnt", 32'(bif.StallCount), 32'd0);
        next_cycle();
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("idle_ctrl", 32'(ctrl), 32'(C_NONE));
        next_cycle();

        set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
        check("lduse_rs2", 32'(ctrl), 32'(C_LDUSE));
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("lduse_one_cycle", 32'(ctrl), 32'(C_NONE));
        check("cnt_lduse", 32'(bif.StallCount), 32'd1);

        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("x0_no_stall", 32'(ctrl), 32'(C_NONE));
        next_cycle();
        check("cnt_x0", 32'(bif.StallCount), 32'd1);

        set_in(1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0);
        check("lduse_rs1", 32'(ctrl), 32'(C_LDUSE));
        next_cycle();
        set_in(1'b0, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0);
        check("no_memread", 32'(ctrl), 32'(C_NONE));
        check("cnt_rs1", 32'(bif.StallCount), 32'd2);

        set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0);
        check("branch_over_lduse", 32'(ctrl), 32'(C_BRANCH));
        next_cycle();
        check("cnt_branch", 32'(bif.StallCount), 32'd2);

        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        check("branch_over_div", 32'(ctrl), 32'(C_BRANCH));
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("branch_no_div_state", 32'(ctrl), 32'(C_NONE));
        next_cycle();

        do_div("div1", 1'b0);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("div1_after", 32'(ctrl), 32'(C_NONE));
        check("cnt_div1", 32'(bif.StallCount), 32'd9);
        next_cycle();

        do_div("b2b_a", 1'b1);
        do_div("b2b_b", 1'b1);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("b2b_after", 32'(ctrl), 32'(C_NONE));
        check("cnt_b2b", 32'(bif.StallCount), 32'd23);
        next_cycle();

        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        check("rdiv_start", 32'(ctrl), 32'(C_DSTART));
        next_cycle();
        check("rdiv_c2", 32'(ctrl), 32'(C_DBUSY));
        next_cycle();
        check("rdiv_c3", 32'(ctrl), 32'(C_DBUSY));
        rst = 1'b0;
        #1;
        check("rdiv_rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check("rdiv_rst_cnt", 32'(bif.StallCount), 32'd0);
        next_cycle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rdiv_release", 32'(ctrl), 32'(C_NONE));
        next_cycle();
        check("rdiv_idle", 32'(ctrl), 32'(C_NONE));

        for (int i = 0; i < 20; i++) begin
            do_div("sat_div", 1'b0);
            if (i == 1) check("sat_cnt_14", 32'(sif.StallCount), 32'd14);
            if (i == 2) check("sat_cnt_15", 32'(sif.StallCount), 32'd15);
        end
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("sat_hold", 32'(sif.StallCount), 32'd15);
        check("cnt_20div", 32'(bif.StallCount), 32'd140);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the EX-stage forwarding logic.
- Generates stall and flush controls for three cases: load-use hazards that forwarding cannot cover, taken-branch redirects, and multi-cycle divide operations.
- Owns a small FSM that holds the pipeline while the iterative divider occupies EX.
- Keeps a saturating count of front-end stall cycles for performance debug.

Parameters:
DIV_LATENCY, 8, number of cycles a divide occupies EX including the issue cycle; legal range 2..32.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  core clock, rising edge.
rst  input  1  asynchronous, active-low reset.
MemReadE  input  1  instruction in EX is a load.
RD_E  input  5  destination register of the EX instruction.
Rs1_D  input  5  source register 1 of the instruction in Decode.
Rs2_D  input  5  source register 2 of the instruction in Decode.
PCSrcE  input  1  taken branch or jump resolved in EX.
DivE  input  1  EX instruction is a divide/remainder.
StallF  output  1  hold PC register.
StallD  output  1  hold IF/ID register.
StallE  output  1  hold ID/EX register.
FlushD  output  1  bubble IF/ID.
FlushE  output  1  bubble ID/EX.
FlushM  output  1  bubble EX/MEM.
DivStart  output  1  one-cycle start pulse to the divider.
DivDone  output  1  final divide cycle; divider result valid in EX.
StallCount  output  CNT_W  saturating count of cycles with StallF=1.

Behaviour:
- Reset: while rst=0, all outputs are 0, the FSM is IDLE, the down-counter is 0 and StallCount is 0. Reset takes effect immediately, including mid-divide; the pending divide is abandoned.
- FSM states: IDLE and DIV_BUSY. Down-counter width is $clog2(DIV_LATENCY).
- IDLE, taken branch (PCSrcE=1):
  - FlushD=1 and FlushE=1; all stalls are 0.
  - DivE is ignored in that cycle: no DivStart and no state change.
- IDLE, divide issue (DivE=1, PCSrcE=0):
  - DivStart=1; StallF, StallD and StallE=1; FlushM=1.
  - At the next edge: go to DIV_BUSY, load counter with DIV_LATENCY-2.
- IDLE, load-use hazard: MemReadE=1, RD_E!=0, and (RD_E==Rs1_D or RD_E==Rs2_D).
  - StallF=1, StallD=1, FlushE=1; StallE=0.
  - Applies only when PCSrcE=0 and DivE=0; a branch overrides the load-use stall.
- DIV_BUSY:
  - StallF, StallD and StallE=1; FlushM=1; FlushD and FlushE=0.
  - Counter decrements every cycle.
  - When the counter is 0: DivDone=1, all stalls and FlushM are 0, and the FSM returns to IDLE at the next edge.
  - Total EX residency of a divide is therefore exactly DIV_LATENCY cycles.
  - PCSrcE, DivE and MemReadE are ignored while in DIV_BUSY.
- Back-to-back divides: a new DivE in the cycle after DivDone starts a fresh sequence. There is no extra gap cycle.
- Control outputs are combinational from state and inputs. There is no register between decision and stall.
- StallCount:
  - Increments on each rising edge where StallF=1.
  - Holds at 2^CNT_W-1 and never wraps.
- x0 never causes a load-use stall.

Test Plan:
- Load x5; next instruction reads x5 via Rs2_D=5, RD_E=5, MemReadE=1 -> StallF=StallD=FlushE=1 for exactly 1 cycle, StallCount=1. Repeat with RD_E=0 -> no stall.
- PCSrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0, StallCount unchanged.
- DivE=1 with DIV_LATENCY=8 -> DivStart for 1 cycle; StallE=1 for 7 cycles; DivDone on cycle 8; pipeline advances at the end of cycle 8; StallCount=7.
- Two divides back-to-back -> two DivStart pulses 8 cycles apart, DivDone twice, no idle gap.
- Deassert rst on cycle 3 of a divide -> all outputs 0 immediately; after release, FSM is IDLE and DivE=0 gives no stall.
- Force CNT_W=4 and hold 20 divides -> StallCount saturates at 15.
